// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions used by the receiver, transmitter and rx FIFO
package uart_pkg;
  localparam int UART_DATA_WIDTH = 8;
  typedef enum logic {PARITY_EVEN = 1'b0, PARITY_ODD = 1'b1} parity_e;
  typedef logic [UART_DATA_WIDTH-1:0] uart_byte_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through synchronous FIFO with registered occupancy
module uart_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic do_push, do_pop;
  assign full = level_q == LVL_FULL;
  assign empty = level_q == '0;
  assign level = level_q;
  assign rdata = mem[rd_ptr_q];
  // a push into a full FIFO is only legal when the head leaves in the same cycle
  always_comb begin
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d = (do_push & ~do_pop) ? level_q + 1'b1 : (do_pop & ~do_push) ? level_q - 1'b1 : level_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr_q] <= wdata;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures one byte per rx_valid rise, drops parity errors, buffers good bytes
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     rx_data,
  input  logic                      rx_valid,
  input  logic                      rx_error,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic [ERR_CNT_WIDTH-1:0]  parity_err_count,
  input  logic                      clear_flags
);
  logic rx_valid_q, overflow_q, overflow_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic capture, good, bad, pop, push, drop;
  uart_sync_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .wdata(rx_data), .pop(pop),
    .rdata(m_data), .level(level), .full(full), .empty(empty)
  );
  assign m_valid = ~empty;
  assign overflow = overflow_q;
  assign parity_err_count = err_cnt_q;
  // set events take priority over clear_flags in the same cycle
  always_comb begin
    capture = rx_valid & ~rx_valid_q;
    good = capture & ~rx_error;
    bad = capture & rx_error;
    pop = m_valid & m_ready;
    push = good & (~full | pop);
    drop = good & full & ~pop;
    overflow_d = drop ? 1'b1 : clear_flags ? 1'b0 : overflow_q;
    err_cnt_d = bad ? (clear_flags ? ERR_CNT_WIDTH'(1) : (&err_cnt_q ? err_cnt_q : err_cnt_q + 1'b1))
                    : (clear_flags ? '0 : err_cnt_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid_q <= 1'b1;
      overflow_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      rx_valid_q <= rx_valid;
      overflow_q <= overflow_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer placed directly downstream of the UART receiver. Captures each received byte once per `rx_valid` assertion, discards bytes flagged with a parity error while counting them, and stores good bytes in a first-word-fall-through FIFO. Software or logic drains the FIFO through a valid/ready read port. Overflow and error conditions are reported as sticky status.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width; matches receiver data width
- DEPTH, 16, FIFO entries; power of two, ≥2
- ERR_CNT_WIDTH, 8, width of the parity-error counter

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rx_data  in  DATA_WIDTH  received byte from the UART receiver
- rx_valid  in  1  receiver data-valid; a level that may stay high for several cycles
- rx_error  in  1  receiver parity error; qualified by the rx_valid rising edge
- m_data  out  DATA_WIDTH  head-of-FIFO byte; valid only when m_valid=1
- m_valid  out  1  FIFO not empty
- m_ready  in  1  consumer accepts m_data when m_valid&m_ready
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full  out  1  level==DEPTH
- empty  out  1  level==0
- overflow  out  1  sticky: a good byte was dropped because the FIFO was full
- parity_err_count  out  ERR_CNT_WIDTH  saturating count of dropped parity-error bytes
- clear_flags  in  1  one-cycle pulse; clears overflow and parity_err_count

## Operation
- Edge detect: `rx_valid_q` is a register holding the previous rx_valid; `capture = rx_valid & !rx_valid_q`. Exactly one capture per rx_valid assertion, regardless of how long it stays high.
- On capture with rx_error=1: byte discarded. parity_err_count increments, saturating at all-ones.
- On capture with rx_error=0:
  - push = 1 if !full, or if full and a pop happens in the same cycle.
  - Otherwise the byte is dropped and overflow is set to 1.
- Pop = m_valid & m_ready. rd_ptr advances.
- Push writes mem[wr_ptr]; wr_ptr advances.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Occupancy:
  - level +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Empty FIFO with capture and m_ready=1: no pop (m_valid=0); the byte is stored and level becomes 1.
- m_data is driven combinationally as mem[rd_ptr] (first-word-fall-through). Memory contents are not reset; m_data is don't-care while m_valid=0.
- clear_flags and a set event in the same cycle: the set wins.
  - overflow ends at 1.
  - parity_err_count ends at 1 if a parity-error capture coincides, otherwise 0.
- Reset values: wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, m_valid=0, overflow=0, parity_err_count=0, rx_valid_q=1.
  - rx_valid_q resets to 1 so that an rx_valid level already high across reset release is not captured.
- Reset mid-operation drops all buffered bytes.

## Timing
- Capture at edge N (rx_valid rises in cycle N): the byte appears on m_data with m_valid=1 after edge N+1, so the consumer sees it in cycle N+1.
- Pop at edge N: the next entry (or m_valid=0) is visible in cycle N+1.
- Throughput: one push and one pop per cycle.
- level, full, empty and overflow are registered and update at the same edge as the push/pop that changes them.
- parity_err_count updates at the capture edge.
- No combinational path from m_ready to m_valid or to m_data.

## Structure
- Shared package `uart_pkg`:
  - UART_DATA_WIDTH=8.
  - Parity type constants: PARITY_EVEN=0, PARITY_ODD=1.
  - A typedef for the byte type.
  - The receiver, transmitter and this block all use the package.
- One sub-module `uart_sync_fifo`: storage, pointers, level, full, empty, push/pop logic.
- The top level holds the edge detect, drop/accept decision, overflow flag and error counter.

## Test plan
- Single byte: rx_data=0xA5 with rx_valid high for 8 cycles -> exactly one entry; m_valid=1 one cycle after the rise, m_data=0xA5, level=1; pop with m_ready=1 gives empty=1.
- Parity error: capture of 0x3C with rx_error=1 -> level stays 0, parity_err_count=1; 255 further errors -> count saturates at 0xFF.
- Fill/overflow with DEPTH=16, m_ready=0:
  - Capture 0x00..0x0F -> full=1, level=16.
  - Capture 0x10 -> dropped, overflow=1, level=16.
  - Drain -> 0x00..0x0F in order, wrap-around exercised.
- Full with simultaneous capture and pop: capture 0x55 while m_ready=1 -> level stays 16, 0x55 ends up last in order, overflow stays 0.
- clear_flags: same cycle as an overflow drop -> overflow=1; alone on the next cycle -> overflow=0 and parity_err_count=0.
- Reset with rx_valid held high and 5 bytes buffered -> level=0, m_valid=0, no capture after release until rx_valid falls and rises again.
